// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains an 8-bit sync FIFO (registered read, 1-cycle latency)
// and serialises each byte as start/data/[parity]/stop on a registered tx line.
module fifo_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       fifo_empty,
   output logic       fifo_rd_en,
   input  logic [7:0] fifo_data,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
   localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);
   localparam logic OddInv = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      StIdle, StFetch, StLoad, StStart, StData, StParity, StStop
   } state_e;

   state_e           state_q, state_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             parity_q, parity_d;
   logic             tx_q, tx_d;
   logic             rd_en_q, rd_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             bit_end;

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      bit_end  = (baud_q == BaudMax);

      unique case (state_q)
         StIdle: begin
            if (enable && !fifo_empty) state_d = StFetch;
         end
         StFetch: state_d = StLoad;
         StLoad: begin
            shift_d  = fifo_data;
            parity_d = (^fifo_data) ^ OddInv;
            baud_d   = '0;
            bit_d    = '0;
            state_d  = StStart;
         end
         StStart: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = StData;
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end
         StData: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = (PARITY_EN != 0) ? StParity : StStop;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end
         StParity: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = StStop;
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end
         StStop: begin
            // bit counter is reused to count stop bits
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == StopLast) begin
                  bit_d   = '0;
                  state_d = StIdle;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Outputs are decoded from next-state values so they register in step with the state.
      rd_en_d = (state_d == StFetch);
      busy_d  = (state_d != StIdle);
      done_d  = (state_d == StStop) && (baud_d == BaudMax) && (bit_d == StopLast);
      unique case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[bit_d];
         StParity: tx_d = parity_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
         rd_en_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
         rd_en_q  <= rd_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign fifo_rd_en = rd_en_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign tx_done    = done_q;

endmodule
